// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : byte-serial single-port RAM arbiter (IF vs MEM) and pipeline
//            stall generator for the 5-stage RISC-V core.
// Rev 1.0
// ============================================================================
module mem_ctrl #(
   parameter int RAM_ADDR_W = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic [31:0]           if_data,
   output logic                  if_done,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [1:0]            mem_width,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   output logic [31:0]           mem_rdata,
   output logic                  mem_done,
   input  logic                  id_stall_req,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic                  ram_we,
   output logic [7:0]            ram_dout,
   input  logic [7:0]            ram_din,
   output logic [5:0]            stall
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      MEM_RD = 2'd2,
      MEM_WR = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            nbytes_q, nbytes_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           acc_q, acc_d;
   logic [31:0]           if_data_q, if_data_d;
   logic                  if_done_q, if_done_d;
   logic [31:0]           mem_rdata_q, mem_rdata_d;
   logic                  mem_done_q, mem_done_d;
   logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic                  ram_we_q, ram_we_d;
   logic [7:0]            ram_dout_q, ram_dout_d;

   logic [2:0]            w_cnt_inc;
   logic [31:0]           w_next_addr;
   logic [31:0]           w_rd_word;
   logic                  w_last;
   logic                  unused_addr_hi;

   // Increment happens on the full 32-bit address; only the low bits reach the RAM.
   assign w_cnt_inc      = cnt_q + 3'd1;
   assign w_next_addr    = addr_q + {29'd0, w_cnt_inc};
   assign w_rd_word      = acc_q | ({24'd0, ram_din} << {cnt_q[1:0], 3'b000});
   assign w_last         = (w_cnt_inc == nbytes_q);
   assign unused_addr_hi = ^w_next_addr[31:RAM_ADDR_W];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      acc_d       = acc_q;
      if_data_d   = if_data_q;
      if_done_d   = 1'b0;
      mem_rdata_d = mem_rdata_q;
      mem_done_d  = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_dout_d  = ram_dout_q;

      case (state_q)
         IDLE: begin
            // A requester whose done pulse is showing is ineligible this cycle.
            if (mem_req && !mem_done_q) begin
               addr_d     = mem_addr;
               cnt_d      = 3'd0;
               acc_d      = 32'd0;
               nbytes_d   = (mem_width == 2'd0) ? 3'd1 :
                            (mem_width == 2'd1) ? 3'd2 : 3'd4;
               ram_addr_d = mem_addr[RAM_ADDR_W-1:0];
               if (mem_we) begin
                  state_d    = MEM_WR;
                  ram_we_d   = 1'b1;
                  ram_dout_d = mem_wdata[7:0];
                  wdata_d    = {8'd0, mem_wdata[31:8]};
               end else begin
                  state_d    = MEM_RD;
               end
            end else if (if_req && !if_done_q) begin
               state_d    = IF_RD;
               addr_d     = if_addr;
               cnt_d      = 3'd0;
               acc_d      = 32'd0;
               nbytes_d   = 3'd4;
               ram_addr_d = if_addr[RAM_ADDR_W-1:0];
            end
         end
         IF_RD, MEM_RD: begin
            acc_d = w_rd_word;
            cnt_d = w_cnt_inc;
            if (w_last) begin
               state_d = IDLE;
               if (state_q == IF_RD) begin
                  if_data_d   = w_rd_word;
                  if_done_d   = 1'b1;
               end else begin
                  mem_rdata_d = w_rd_word;
                  mem_done_d  = 1'b1;
               end
            end else begin
               ram_addr_d = w_next_addr[RAM_ADDR_W-1:0];
            end
         end
         MEM_WR: begin
            cnt_d = w_cnt_inc;
            if (w_last) begin
               state_d    = IDLE;
               mem_done_d = 1'b1;
            end else begin
               ram_we_d   = 1'b1;
               ram_addr_d = w_next_addr[RAM_ADDR_W-1:0];
               ram_dout_d = wdata_q[7:0];
               wdata_d    = {8'd0, wdata_q[31:8]};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         nbytes_q    <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         acc_q       <= 32'd0;
         if_data_q   <= 32'd0;
         if_done_q   <= 1'b0;
         mem_rdata_q <= 32'd0;
         mem_done_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_dout_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbytes_q    <= nbytes_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         acc_q       <= acc_d;
         if_data_q   <= if_data_d;
         if_done_q   <= if_done_d;
         mem_rdata_q <= mem_rdata_d;
         mem_done_q  <= mem_done_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_dout_q  <= ram_dout_d;
      end
   end

   // A pending MEM access freezes everything up to MEM, even over an in-flight fetch.
   always_comb begin
      stall = 6'b000000;
      if (mem_req && !mem_done_q) begin
         stall = 6'b011111;
      end else if ((if_req && !if_done_q) || id_stall_req) begin
         stall = id_stall_req ? 6'b000111 : 6'b000011;
      end
   end

   assign if_data   = if_data_q;
   assign if_done   = if_done_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_done  = mem_done_q;
   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_dout  = ram_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : table vectors, hand-written corner sequences and randomized
//               transactions checked against a byte-array memory model.
// Rev 1.0
// ============================================================================
module tb_mem_ctrl;
   localparam int RAM_ADDR_W = 17;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  if_req;
   logic [31:0]           if_addr;
   logic [31:0]           if_data;
   logic                  if_done;
   logic                  mem_req;
   logic                  mem_we;
   logic [1:0]            mem_width;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  mem_done;
   logic                  id_stall_req;
   logic [RAM_ADDR_W-1:0] ram_addr;
   logic                  ram_we;
   logic [7:0]            ram_dout;
   logic [7:0]            ram_din = 8'd0;
   logic [5:0]            stall;

   mem_ctrl #(.RAM_ADDR_W(RAM_ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_data      (if_data),
      .if_done      (if_done),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_width    (mem_width),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_done     (mem_done),
      .id_stall_req (id_stall_req),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_dout     (ram_dout),
      .ram_din      (ram_din),
      .stall        (stall)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Environment RAM (driven by the DUT) and reference memory (driven by the model).
   logic [7:0]  ram_mem [int];
   logic [7:0]  ref_mem [int];
   logic [24:0] wlog [$];
   logic        poke_en = 1'b0;
   int          poke_a  = 0;
   logic [7:0]  poke_d  = 8'd0;

   function automatic logic [7:0] dflt(input int a);
      logic [31:0] v;
      v = a;
      return v[7:0] ^ {v[12:9], v[16:13]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(input int a);
      return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
   endfunction

   function automatic logic [7:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic int ta(input logic [31:0] a);
      return int'(a[RAM_ADDR_W-1:0]);
   endfunction

   function automatic int nbytes(input logic [1:0] w);
      return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
   endfunction

   always @(posedge clk) begin
      if (poke_en) begin
         ram_mem[poke_a] = poke_d;
      end else if (ram_we) begin
         ram_mem[int'(ram_addr)] = ram_dout;
         wlog.push_back({ram_addr, ram_dout});
      end
   end

   always @(negedge clk) ram_din <= ram_rd(int'(ram_addr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      ref_mem[a] = d;
      poke_en = 1'b1; poke_a = a; poke_d = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
      logic [31:0] r;
      r = 32'd0;
      for (int k = 0; k < n; k++) r = r | (32'(ref_rd(ta(a + 32'(k)))) << (8 * k));
      return r;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int n);
      for (int k = 0; k < n; k++) ref_mem[ta(a + 32'(k))] = d[8*k +: 8];
   endtask

   // One complete transaction starting from an idle controller with no done pulse showing.
   task automatic run_op(input bit is_if, input bit we, input logic [1:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data);
      int         n, cyc;
      bit         stall_ok, addr_ok, wok, done;
      logic [5:0] busy;
      logic [24:0] ew;
      n    = is_if ? 4 : nbytes(width);
      busy = is_if ? 6'b000011 : 6'b011111;
      wlog.delete();
      if (is_if) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         mem_req = 1'b1; mem_we = we; mem_width = width; mem_addr = addr; mem_wdata = wdata;
      end
      cyc = 0; stall_ok = 1'b1; addr_ok = 1'b1; done = 1'b0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         done = is_if ? if_done : mem_done;
         if (!done) begin
            if (stall !== busy) stall_ok = 1'b0;
            if (cyc <= n && int'(ram_addr) != ta(addr + 32'(cyc - 1))) addr_ok = 1'b0;
         end
      end
      chk("latency", cyc, n + 1);
      chk("stall_busy", {31'd0, stall_ok}, 32'd1);
      chk("ram_addr_seq", {31'd0, addr_ok}, 32'd1);
      chk("stall_at_done", {26'd0, stall}, 32'd0);
      chk("we_at_done", {31'd0, ram_we}, 32'd0);
      data = is_if ? if_data : mem_rdata;
      if (is_if) if_req = 1'b0; else mem_req = 1'b0;
      if (!is_if && we) begin
         wok = (wlog.size() == n);
         for (int k = 0; k < n; k++) begin
            ew = {ram_addr_w(addr + 32'(k)), wdata[8*k +: 8]};
            if (k >= wlog.size() || wlog[k] !== ew) wok = 1'b0;
         end
         chk("write_bytes", {31'd0, wok}, 32'd1);
      end else begin
         chk("no_write", wlog.size(), 32'd0);
      end
      @(posedge clk); #1;
      chk("done_one_cycle", {30'd0, if_done, mem_done}, 32'd0);
      if (is_if || !we) chk("data_hold", is_if ? if_data : mem_rdata, data);
   endtask

   function automatic logic [RAM_ADDR_W-1:0] ram_addr_w(input logic [31:0] a);
      return a[RAM_ADDR_W-1:0];
   endfunction

   typedef struct {
      bit          is_if;
      bit          we;
      logic [1:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [31:0] d, e, mrd, ifd;
      int          md1, md2, idn, act;
      bit          quiet, got;
      bit          r_if, r_we;
      logic [1:0]  r_w;
      logic [31:0] r_a, r_d;

      vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h00A0_0513};
      vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000_2001, 32'h1234_BEEF, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'h22BE_EF11};
      vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0030, 32'h0,         32'h0000_0080};
      vecs[4]  = '{1'b0, 1'b0, 2'd1, 32'h0000_2002, 32'h0,         32'h0000_22BE};
      vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 2'd3, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF};
      vecs[7]  = '{1'b0, 1'b0, 2'd0, 32'h0000_3003, 32'h0,         32'h0000_00DE};
      vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA};
      vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_005A, 32'h0};
      vecs[10] = '{1'b0, 1'b0, 2'd1, 32'h0001_FFFF, 32'h0,         32'h0000_CC5A};
      vecs[11] = '{1'b1, 1'b0, 2'd2, 32'h0002_0100, 32'h0,         32'h00A0_0513};

      rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
      mem_width = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0; id_stall_req = 1'b0;
      @(posedge clk); #1;
      poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
      poke(32'h2000, 8'h11); poke(32'h2003, 8'h22); poke(32'h30, 8'h80);
      poke(32'h1FFFE, 8'hAA); poke(32'h1FFFF, 8'hBB); poke(32'h0, 8'hCC); poke(32'h1, 8'hDD);

      chk("reset_ctrl", {14'd0, ram_addr, ram_we, if_done, mem_done}, 32'd0);
      chk("reset_data", if_data | mem_rdata | {24'd0, ram_dout}, 32'd0);
      chk("reset_stall", {26'd0, stall}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].is_if, vecs[i].we, vecs[i].width, vecs[i].addr, vecs[i].wdata, d);
         if (!vecs[i].is_if && vecs[i].we)
            model_write(vecs[i].addr, vecs[i].wdata, nbytes(vecs[i].width));
         else
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      end

      // Simultaneous requests, then a MEM request arriving during a fetch.
      if_req = 1'b1; if_addr = 32'h100;
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h30;
      #1 chk("stall_both", {26'd0, stall}, 32'h1F);
      md1 = 0; md2 = 0; idn = 0; mrd = 32'd0; ifd = 32'd0;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         if (mem_done) begin
            if (md1 == 0) begin
               md1 = c;
               chk("stall_after_mem", {26'd0, stall}, 32'h03);
            end else begin
               md2 = c;
            end
            mrd = mem_rdata;
            mem_req = 1'b0;
         end
         if (if_done) begin
            idn = c; ifd = if_data; if_req = 1'b0;
         end
         if (c == 4) begin
            mem_req = 1'b1;
            #1 chk("stall_mem_over_if", {26'd0, stall}, 32'h1F);
         end
      end
      chk("arb_mem_done_cyc", md1, 2);
      chk("arb_if_done_cyc", idn, 7);
      chk("arb_mem2_done_cyc", md2, 9);
      chk("arb_mem_data", mrd, 32'h80);
      chk("arb_if_data", ifd, 32'h00A0_0513);

      // Load-use stall request alone, then with a pending MEM access.
      id_stall_req = 1'b1;
      #1 chk("stall_id", {26'd0, stall}, 32'h07);
      quiet = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (ram_we || if_done || mem_done || stall !== 6'b000111) quiet = 1'b0;
      end
      chk("id_quiet", {31'd0, quiet}, 32'd1);
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h2003;
      #1 chk("stall_id_mem", {26'd0, stall}, 32'h1F);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(posedge clk); #1;
         got = mem_done;
      end
      chk("id_mem_done", {31'd0, got}, 32'd1);
      chk("id_mem_data", mem_rdata, 32'h22);
      chk("stall_id_at_done", {26'd0, stall}, 32'h07);
      mem_req = 1'b0; id_stall_req = 1'b0;
      @(posedge clk); #1;

      // Reset asserted in the middle of a word fetch.
      if_req = 1'b1; if_addr = 32'h100;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; if_req = 1'b0;
      #1;
      chk("rst_mid_ctrl", {14'd0, ram_addr, ram_we, if_done, mem_done}, 32'd0);
      chk("rst_mid_data", if_data | mem_rdata | {24'd0, ram_dout}, 32'd0);
      chk("rst_mid_stall", {26'd0, stall}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      act = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (if_done || mem_done) act++;
      end
      chk("rst_no_done", act, 0);
      run_op(1'b1, 1'b0, 2'd2, 32'h100, 32'd0, d);
      chk("rst_refetch", d, 32'h00A0_0513);

      // Randomized transactions against the memory model.
      for (int i = 0; i < 60; i++) begin
         r_if = ($urandom_range(0, 2) == 0);
         r_we = $urandom_range(0, 1) == 1;
         r_w  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       r_a = 32'($urandom_range(0, 63));
            1:       r_a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            2:       r_a = 32'h0001_FFFC + 32'($urandom_range(0, 3));
            default: r_a = $urandom();
         endcase
         r_d = $urandom();
         run_op(r_if, r_we, r_w, r_a, r_d, d);
         if (!r_if && r_we) begin
            model_write(r_a, r_d, nbytes(r_w));
         end else begin
            e = model_read(r_a, r_if ? 4 : nbytes(r_w));
            chk($sformatf("rand%0d_data", i), d, e);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller and stall generator for the 5-stage RISC-V pipeline.
- Shares the byte-wide synchronous RAM port between instruction fetch (IF) and data access (MEM).
- Serialises each access into byte transfers and drives the 6-bit stall vector consumed by PC and all pipeline registers. Stall bits: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
- A stage register inserts a bubble when its own bit is set and the next bit is clear.

Parameters:
RAM_ADDR_W, 17, width of ram_addr; the 32-bit byte address is truncated to its low RAM_ADDR_W bits.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_done
if_addr  in  32  fetch byte address
if_data  out  32  fetched instruction, valid while if_done=1
if_done  out  1  one-cycle fetch completion pulse
mem_req  in  1  load/store request; held until mem_done
mem_we  in  1  1=store, 0=load
mem_width  in  2  0=byte, 1=half, 2/3=word
mem_addr  in  32  data byte address
mem_wdata  in  32  store data
mem_rdata  out  32  load data, little-endian, zero-extended, valid while mem_done=1
mem_done  out  1  one-cycle load/store completion pulse
id_stall_req  in  1  load-use hazard request from ID
ram_addr  out  RAM_ADDR_W  RAM byte address
ram_we  out  1  RAM write enable
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid the cycle after its address
stall  out  6  pipeline stall vector

Behaviour:
Reset (rst=0, async):
- All registered outputs 0. FSM goes to IDLE; byte counter 0.
- An in-flight transaction is abandoned; no done pulse follows.

FSM states: IDLE, IF_RD, MEM_RD, MEM_WR.
- Byte count N: IF=4; MEM per mem_width = 1, 2 or 4.

Grant (IDLE only):
- A requester is eligible if its req=1 and its done output is currently 0.
- MEM has priority over IF.
- Grant edge E0 latches the address, data, width and we; the counter resets to 0.
- A transaction is never preempted.

Read (IF_RD/MEM_RD):
- After E0, ram_addr = A+0, ram_we=0. After edge Ek, ram_addr = A+k for k<N.
- Byte k is taken from ram_din at edge E(k+1) into bits [8k+7:8k].
- At E(N): done=1 for one cycle, data is final, state returns to IDLE.
- Unread upper bytes are 0.

Write (MEM_WR):
- After Ek (k<N): ram_addr=A+k, ram_we=1, ram_dout = wdata[8k+7:8k].
- At E(N): ram_we=0, mem_done=1 for one cycle, state returns to IDLE.

Latency and arithmetic:
- Done is high in the cycle after edge E(N) for both reads and writes.
- Address increment is 32-bit modulo 2^32 before truncation (0xFFFFFFFF+1 = 0).
- if_data and mem_rdata hold their last value outside done cycles.

Back-to-back:
- The done cycle is spent in IDLE. The just-finished requester is ineligible, so the other requester can be granted at that edge.
- Minimum gap between two grants of the same requester is 1 IDLE cycle.

Stall (combinational from registered state and inputs):
- mem_req & ~mem_done -> 6'b011111.
- else (if_req & ~if_done) | id_stall_req -> id_stall_req ? 6'b000111 : 6'b000011.
- else 6'b000000.
- MEM takes precedence even while an IF transaction is in flight.

Request rules:
- A req dropped mid-transaction does not abort it. The done pulse is still produced and ignored.
- ram_we is never 1 outside MEM_WR.

Test Plan:
- Reset mid word-read (deassert rst at E2) -> all outputs 0 immediately, state IDLE, no if_done; next if_req restarts at byte 0.
- IF fetch 0x00000100, RAM bytes 13,05,A0,00 -> ram_addr 0x100..0x103, if_done after E4, if_data=0x00A00513, stall=6'b000011 until done cycle, 0 at done.
- Store half 0xBEEF to 0x2001 -> two ram_we cycles, (0x2001,EF),(0x2002,BE), mem_done after E2, stall=6'b011111 throughout, ram_we=0 at done.
- if_req and mem_req (byte load 0x30, RAM=0x80) together in IDLE -> MEM granted first, mem_rdata=0x00000080 after E1; IF granted on the mem_done edge; stall shows 6'b011111 then 6'b000011.
- IF word read at 0xFFFFFFFE with RAM_ADDR_W=17 -> ram_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- id_stall_req=1 with no memory activity -> stall=6'b000111, ram_we=0, no done pulses; same with mem_req pending -> 6'b011111.
